// File: rtl/com_uart_tx_arbiter.sv
// com_uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between NUM_REQ
// byte-stream requesters. A grant is held for one packet or for at most
// BURST_MAX bytes. Each byte is launched with a one-cycle tx_start pulse,
// and the next byte is offered only after the transmitter's busy window ends.
//
// Optional feature: define COM_UART_ARB_IDLE_TIMEOUT_EN to release a grant
// whose owner stalls for 64 consecutive cycles in LOAD.
module com_uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,   // 2..8
    parameter int BURST_MAX   = 4,   // 1..15
    parameter int ACK_TIMEOUT = 15   // 1..255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic                 ack_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t     state;
    logic [2:0] rr_ptr;
    logic [3:0] burst_cnt;
    logic [7:0] ack_cnt;
    logic       last_q;

    logic [7:0] valid_ext;   // req_valid widened so a 3-bit index is always legal
    logic [7:0] sel_data;
    logic       sel_last;
    logic       pick_found;
    logic [2:0] pick_id;
    logic [3:0] cand;
    logic [2:0] next_ptr;
    logic       do_release;
    logic       stall_hit;

`ifdef COM_UART_ARB_IDLE_TIMEOUT_EN
    localparam int STALL_LIMIT = 64;
    logic [7:0] stall_cnt;

    // The owner has been silent for STALL_LIMIT consecutive LOAD cycles.
    assign stall_hit = (state == LOAD) && !valid_ext[grant_id] &&
                       (stall_cnt == 8'(STALL_LIMIT - 1));
`else
    // Without the idle timeout LOAD waits for the owner indefinitely.
    assign stall_hit = 1'b0;
`endif

    // Route the owner's byte, last flag and ready; ready only while in LOAD.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
        valid_ext = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_ext[i] = req_valid[i];
            if (grant_id == 3'(i)) begin
                sel_data     = req_data[8*i +: 8];
                sel_last     = req_last[i];
                req_ready[i] = (state == LOAD);
            end
        end
    end

    // First valid requester at or above the pointer, wrapping at NUM_REQ.
    // Walking the offsets downward lets the smallest offset win.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (valid_ext[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[2:0];
            end
        end
    end

    // Pointer value after the current owner gives up the transmitter.
    assign next_ptr = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

    // Conditions that end the current grant.
    always_comb begin
        do_release = 1'b0;
        case (state)
            LOAD:      do_release = stall_hit;
            WAIT_ACK:  do_release = !tx_busy && (ack_cnt <= 8'd1);
            WAIT_DONE: do_release = !tx_busy && (last_q || burst_cnt == 4'(BURST_MAX));
            default:   do_release = 1'b0;
        endcase
    end

    // Sequencer FSM with registered grant, launch and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            ack_cnt     <= '0;
            last_q      <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ack_err     <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            tx_start <= 1'b0;
            ack_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_valid <= 1'b1;
                        grant_id    <= pick_id;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (valid_ext[grant_id]) begin
                        tx_data   <= sel_data;
                        last_q    <= sel_last;
                        burst_cnt <= burst_cnt + 4'd1;
                        tx_start  <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // tx_busy may rise on any of the next ACK_TIMEOUT cycles.
                    ack_cnt <= 8'(ACK_TIMEOUT);
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt <= 8'd1) begin
                        ack_err <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt - 8'd1;
                    end
                end
                WAIT_DONE: begin
                    // Overridden below when the packet or burst is complete.
                    if (!tx_busy) begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_release) begin
                grant_valid <= 1'b0;
                grant_id    <= '0;
                burst_cnt   <= '0;
                rr_ptr      <= next_ptr;
                state       <= IDLE;
            end
        end
    end

`ifdef COM_UART_ARB_IDLE_TIMEOUT_EN
    // Count consecutive stalled LOAD cycles; any other cycle clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == LOAD && !valid_ext[grant_id]) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_com_uart_tx_arbiter.sv
// Self-checking bench for com_uart_tx_arbiter (NUM_REQ=4, BURST_MAX=4,
// ACK_TIMEOUT=15). A cycle table covers the single-byte transaction, and
// hand sequences cover ordering, bursts, ack timeout, reset and stall.
// Randomised packet traffic is checked against a transaction-level
// round-robin model.
module tb_com_uart_tx_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int BURST_MAX   = 4;
    localparam int ACK_TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [2:0]           grant_id;
    logic                 ack_err;

    com_uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BURST_MAX  (BURST_MAX),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } byte_t;

    typedef struct {
        int         id;
        logic [7:0] d;
    } launch_t;

    // Field order: inputs (valid, last, data, busy), then expected outputs
    // (grant_valid, grant_id, req_ready, tx_start, tx_data, ack_err).
    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        busy;
        logic        gv;
        logic [2:0]  gid;
        logic [3:0]  ready;
        logic        start;
        logic [7:0]  txd;
        logic        err;
    } vec_t;

    vec_t    tbl[8];
    byte_t   rq[NUM_REQ][$];   // bytes each requester still has to offer
    launch_t exp_q[$];         // launches the model predicts, in order
    int      m_ptr;            // model's round-robin pointer

    int checks = 0;
    int errors = 0;

    // Transmitter model state.
    bit tx_auto;
    int fix_lat;
    int fix_len;
    int tcyc;
    int busy_from;
    int busy_to;

    // Outputs sampled by step().
    logic       s_start, s_err, s_gv;
    logic [2:0] s_gid;
    logic [7:0] s_data;
    logic [3:0] s_ready;
    int         ack_seen;
    int         viol;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    function automatic void push_packet(input int id, input int len);
        for (int j = 0; j < len; j++) begin
            byte_t b;
            b.d    = 8'($urandom);
            b.last = (j == len - 1);
            rq[id].push_back(b);
        end
    endfunction

    // Transaction-level round robin: whoever holds data, starting at the
    // pointer, sends until its packet ends or BURST_MAX bytes went out.
    function automatic void build_expected();
        byte_t mq[NUM_REQ][$];
        int    owner;
        int    n;
        bit    done;
        byte_t b;
        launch_t l;
        for (int i = 0; i < NUM_REQ; i++) mq[i] = rq[i];
        while (1) begin
            owner = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (owner < 0 && mq[(m_ptr + k) % NUM_REQ].size() != 0) begin
                    owner = (m_ptr + k) % NUM_REQ;
                end
            end
            if (owner < 0) break;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                b    = mq[owner].pop_front();
                l.id = owner;
                l.d  = b.d;
                exp_q.push_back(l);
                n++;
                if (b.last || n == BURST_MAX || mq[owner].size() == 0) done = 1'b1;
            end
            m_ptr = (owner + 1) % NUM_REQ;
        end
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0].d;
                req_last[i]        = rq[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: sample at negedge, then update requesters and tx_busy after posedge.
    task automatic step();
        logic [3:0] hs;
        int lat;
        int len;
        @(negedge clk);
        s_start = tx_start;
        s_err   = ack_err;
        s_gv    = grant_valid;
        s_gid   = grant_id;
        s_data  = tx_data;
        s_ready = req_ready;
        if (s_err) ack_seen++;
        if (s_ready != 4'b0 && (!s_gv || s_ready != (4'b1 << s_gid))) viol++;
        if (s_start && tx_auto) begin
            lat       = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
            len       = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
            busy_from = tcyc + 1 + lat;
            busy_to   = busy_from + len;
        end
        hs = req_valid & s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        end
        drive_reqs();
        tcyc++;
        tx_busy = tx_auto && (tcyc >= busy_from) && (tcyc < busy_to);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        step();
        while (!s_start && n < budget) begin
            step();
            n++;
        end
    endtask

    // Run queued traffic to completion and compare every launch with the model.
    task automatic run_queues(input int budget);
        int      n = 0;
        int      extra = 0;
        int      ack0 = ack_seen;
        int      viol0 = viol;
        bit      done = 1'b0;
        launch_t e;
        tx_auto = 1'b1;
        build_expected();
        drive_reqs();
        while (!done && n < budget) begin
            step();
            n++;
            if (s_start) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    check("launch_id", 32'(s_gid), 32'(e.id));
                    check("launch_data", 32'(s_data), 32'(e.d));
                end
            end
            done = (exp_q.size() == 0) && all_empty() && !s_gv;
        end
        check("run_done", 32'(done), 32'd1);
        check("launch_extra", 32'(extra), 32'd0);
        check("run_ack_err", 32'(ack_seen - ack0), 32'd0);
        check("run_ready_onehot", 32'(viol - viol0), 32'd0);
        exp_q.delete();
    endtask

    task automatic apply_table();
        for (int r = 0; r < 8; r++) begin
            @(posedge clk);
            #1;
            req_valid = tbl[r].valid;
            req_last  = tbl[r].last;
            req_data  = tbl[r].data;
            tx_busy   = tbl[r].busy;
            @(negedge clk);
            check($sformatf("row%0d_grant_valid", r), 32'(grant_valid), 32'(tbl[r].gv));
            check($sformatf("row%0d_grant_id", r), 32'(grant_id), 32'(tbl[r].gid));
            check($sformatf("row%0d_req_ready", r), 32'(req_ready), 32'(tbl[r].ready));
            check($sformatf("row%0d_tx_start", r), 32'(tx_start), 32'(tbl[r].start));
            check($sformatf("row%0d_tx_data", r), 32'(tx_data), 32'(tbl[r].txd));
            check($sformatf("row%0d_ack_err", r), 32'(ack_err), 32'(tbl[r].err));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_ack_err"}, 32'(ack_err), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int e0;
        int st;
        byte_t b;

        // Requester 2 sends 0xA5 with last=1; tx_busy high for two cycles.
        tbl[0] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{4'b0100, 4'b0100, 32'h00A5_0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{4'b0100, 4'b0100, 32'h00A5_0000, 1'b0, 1'b1, 3'd2, 4'b0100, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b1, 8'hA5, 1'b0};
        tbl[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 3'd2, 4'b0000, 1'b0, 8'hA5, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 3'd2, 4'b0000, 1'b0, 8'hA5, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b0, 8'hA5, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 8'hA5, 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_auto   = 1'b0;
        fix_lat   = -1;
        fix_len   = 0;
        tcyc      = 0;
        busy_from = 0;
        busy_to   = 0;
        ack_seen  = 0;
        viol      = 0;
        m_ptr     = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single byte from requester 2; its release leaves the pointer at 3.
        apply_table();
        m_ptr = 3;

        // Pointer 3: requester 3 before 0.
        push_packet(0, 1);
        push_packet(3, 1);
        run_queues(500);
        // Pointer 1: requester 3 before 0 again.
        push_packet(0, 1);
        push_packet(3, 1);
        run_queues(500);
        // Move the pointer to 0, then requester 0 before 3.
        push_packet(3, 1);
        run_queues(500);
        push_packet(0, 1);
        push_packet(3, 1);
        run_queues(500);

        // Requester 1 sends 6 bytes; the burst limit splits them 4 + 2.
        push_packet(1, 6);
        push_packet(0, 2);
        push_packet(2, 1);
        push_packet(3, 1);
        run_queues(1000);

        // tx_busy never rises: one ack_err ACK_TIMEOUT+1 cycles after tx_start.
        tx_auto = 1'b0;
        tx_busy = 1'b0;
        b.d     = 8'h5A;
        b.last  = 1'b1;
        rq[0].push_back(b);
        drive_reqs();
        wait_start(20);
        check("ack_launch_seen", 32'(s_start), 32'd1);
        check("ack_launch_data", 32'(s_data), 32'h5A);
        n = 0;
        s_err = 1'b0;
        while (!s_err && n < 40) begin
            step();
            n++;
        end
        check("ack_latency", 32'(n), 32'(ACK_TIMEOUT + 1));
        check("ack_release", 32'(s_gv), 32'd0);
        e0 = ack_seen;
        st = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_start) st++;
        end
        check("ack_single_pulse", 32'(ack_seen - e0), 32'd0);
        check("ack_no_relaunch", 32'(st), 32'd0);
        m_ptr = 1;

        // Reset while the transmitter is shifting (WAIT_DONE).
        tx_auto = 1'b1;
        fix_lat = 0;
        fix_len = 12;
        b.d     = 8'h77;
        b.last  = 1'b1;
        rq[2].push_back(b);
        drive_reqs();
        wait_start(20);
        check("rst_launch_seen", 32'(s_start), 32'd1);
        repeat (4) step();
        check("rst_pre_grant", 32'(s_gv), 32'd1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        tx_auto = 1'b0;
        tx_busy = 1'b0;
        fix_lat = -1;
        fix_len = 0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        apply_table();
        m_ptr = 3;

        // Randomised packet traffic against the round-robin model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 1) == 1 || i == r % NUM_REQ) begin
                    int np;
                    np = $urandom_range(1, 2);
                    for (int p = 0; p < np; p++) push_packet(i, $urandom_range(1, 6));
                end
            end
            run_queues(3000);
        end

        // Owner stalls mid-packet after one byte.
        tx_auto = 1'b1;
        b.d     = 8'h11;
        b.last  = 1'b0;
        rq[1].push_back(b);
        drive_reqs();
        wait_start(40);
        check("stall_launch_seen", 32'(s_start), 32'd1);
        e0 = ack_seen;
`ifdef COM_UART_ARB_IDLE_TIMEOUT_EN
        n = 0;
        while (s_gv && n < 200) begin
            step();
            n++;
        end
        check("stall_released", 32'(s_gv), 32'd0);
        check("stall_not_early", 32'(n >= 64), 32'd1);
        check("stall_no_ack_err", 32'(ack_seen - e0), 32'd0);
`else
        repeat (1000) step();
        check("stall_grant_held", 32'(s_gv), 32'd1);
        check("stall_grant_id", 32'(s_gid), 32'd1);
        check("stall_ready", 32'(s_ready), 32'b0010);
        check("stall_no_ack_err", 32'(ack_seen - e0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/com_uart_tx_arbiter.md
# com_uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter between several byte-stream requesters. Each requester offers bytes over a valid/ready handshake. The arbiter grants one requester at a time, and holds the grant for a packet or burst. It launches each byte into the transmitter with a one-cycle start pulse and waits out the transmitter's busy window before offering the next byte. It sits between the core-side peripherals (debug console, DMA, interrupt reporter) and the UART transmit datapath.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- BURST_MAX, 4: maximum bytes per grant before a forced re-arbitration, 1..15.
- ACK_TIMEOUT, 15: cycles allowed for tx_busy to rise after tx_start, 1..255.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset: asynchronous, active-low.
- req_valid  input  NUM_REQ  requester i has a byte on req_data[8i+7:8i].
- req_data  input  8*NUM_REQ  packed request bytes.
- req_last  input  NUM_REQ  byte is the last of requester i's packet.
- req_ready  output  NUM_REQ  one-hot; byte accepted when valid&ready.
- tx_data  output  8  byte to transmitter, held stable until tx_busy falls.
- tx_start  output  1  one-cycle launch pulse.
- tx_busy  input  1  transmitter shifting a frame, synchronous to clk.
- grant_valid  output  1  a requester currently owns the transmitter.
- grant_id  output  3  index of owner; 0 when grant_valid=0.
- ack_err  output  1  one-cycle pulse: tx_busy never rose after tx_start.

## Operation
- States: IDLE, LOAD, LAUNCH, WAIT_ACK, WAIT_DONE.
- Reset values: state IDLE, all outputs 0, RR pointer 0, burst counter 0.
- IDLE: if any req_valid, pick the first set bit searching from pointer upward, with wrap. Register grant_id and set grant_valid. Go to LOAD. Otherwise stay in IDLE.
- LOAD: req_ready[grant_id]=1 (combinational, only in LOAD).
  - If req_valid[grant_id]=1: capture the byte into tx_data, capture req_last, increment the 4-bit burst counter, go to LAUNCH.
  - If req_valid[grant_id]=0: stay in LOAD. No timeout in the base build (see Configuration).
- LAUNCH: tx_start=1 for exactly this cycle. Go to WAIT_ACK. Load the ACK_TIMEOUT counter.
- WAIT_ACK: when tx_busy=1, go to WAIT_DONE. If the counter reaches 0 first, pulse ack_err, release the grant, and go to IDLE.
- WAIT_DONE: when tx_busy=0:
  - Release the grant if the captured req_last=1 or burst counter==BURST_MAX. Otherwise go back to LOAD.
- Release: grant_valid=0, grant_id=0, burst counter 0, pointer = (owner+1) mod NUM_REQ, state IDLE.
- Requesters without a grant are never acknowledged. Changes on req_valid during a burst do not affect the owner.
- Requester indices >= NUM_REQ do not exist. The pointer wraps at NUM_REQ-1 to 0.

## Timing
- Request seen in IDLE at edge N: grant_valid at N+1, req_ready at N+1 (same cycle as LOAD), tx_start at N+2.
- Byte-to-byte within a burst: minimum 2 cycles after tx_busy falls (LOAD, then LAUNCH).
- tx_data stays constant from LAUNCH until the next LOAD capture.
- If tx_busy is already 1 during LAUNCH, WAIT_ACK exits on the following cycle.
- rst_n assertion mid-frame: immediate return to reset values. tx_start is never extended. A frame already launched in the transmitter is not aborted.
- Idle-grant boundary: the owner's pointer advances even if its packet ended by burst limit. The owner requesting again must wait its turn.

## Configuration
- COM_UART_ARB_IDLE_TIMEOUT_EN defined: LOAD carries an 8-bit stall counter.
  - After 64 consecutive cycles with req_valid[grant_id]=0, the grant is released: pointer advances and state goes to IDLE, with no error pulse.
  - The counter clears on every accepted byte.
- Undefined: LOAD waits indefinitely for the owner's next byte, and the stall counter is not present.

## Test plan
- Single requester 2 sends 0xA5 with last=1: grant_id=2, tx_start one cycle, tx_data=0xA5. Grant drops when tx_busy falls, and the pointer becomes 3.
- Requesters 0 and 3 valid together, pointer 0: 0 served first, then 3. With pointer 1, 3 is served before 0.
- Requester 1 streams 6 bytes with last only on byte 6, BURST_MAX=4: 4 bytes sent, grant released, other valid requesters served, then the remaining 2 bytes.
- tx_busy held 0 after tx_start, ACK_TIMEOUT=15: ack_err pulses once at 16 cycles after LAUNCH, grant released, no further tx_start.
- rst_n low during WAIT_DONE: all outputs 0 next cycle. After release, the first request behaves per the first scenario.
- With COM_UART_ARB_IDLE_TIMEOUT_EN, owner stalls mid-packet: grant released after 64 cycles. Without it, the grant is still held after 1000 cycles.
